// File: rtl/door_lock_sequencer_pkg.sv
// Shared definitions for the keypad door-lock sequencer: state encodings,
// default cycle constants and the saturating failure-count helper.
package door_lock_sequencer_pkg;

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_UNLOCKED = 2'd1,
        S_AJAR     = 2'd2,
        S_LOCKOUT  = 2'd3
    } lock_state_t;

    localparam int DEF_MAX_FAIL    = 3;
    localparam int DEF_AJAR_CYC    = 20;
    localparam int DEF_LOCKOUT_CYC = 60;
    localparam int DEF_TW          = 7;

    // Increment a failure count without going past the lockout limit.
    function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] lim);
        return (v >= lim) ? lim : v + 2'd1;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Down counter shared by the door-ajar and lockout countdowns. A load wins
// over counting; the count holds at zero instead of wrapping.
module lock_timer #(
    parameter int TW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          zero
);

    logic [TW-1:0] r_count;

    // Load or decrement, saturating at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/door_lock_sequencer.sv
// Central sequencer of the keypad door lock. Registers the keypad verdicts and
// the button/sensor levels, runs the LOCKED/UNLOCKED/AJAR/LOCKOUT FSM, owns the
// failed-attempt counter and drives registered Moore outputs.
module door_lock_sequencer
    import door_lock_sequencer_pkg::*;
#(
    parameter int MAX_FAIL    = DEF_MAX_FAIL,
    parameter int AJAR_CYC    = DEF_AJAR_CYC,
    parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC,
    parameter int TW          = DEF_TW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pw_ok,
    input  logic       pw_fail,
    input  logic       open_button,
    input  logic       close_sensor,
    output logic       unlock,
    output logic       alert,
    output logic       lockout,
    output logic [1:0] fail_cnt,
    output logic [1:0] state
);

    localparam logic [1:0]    MAX_FAIL_V = 2'(MAX_FAIL);
    localparam logic [TW-1:0] AJAR_VAL   = TW'(AJAR_CYC - 1);
    localparam logic [TW-1:0] LOCK_VAL   = TW'(LOCKOUT_CYC - 1);

    lock_state_t r_state;
    lock_state_t w_state_nx;
    logic [1:0]  r_fail_cnt;
    logic [1:0]  w_fail_nx;
    logic        r_unlock;
    logic        r_alert;
    logic        r_lockout;

    logic        r_pw_ok;
    logic        r_pw_fail;
    logic        r_open_q;
    logic        r_open_q2;
    logic        r_close_q;
    logic        r_close_q2;
    logic        w_open_re;
    logic        w_close_re;

    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_en;
    logic          w_tmr_zero;

    // Sample the inputs once; keep the previous button/sensor level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pw_ok    <= 1'b0;
            r_pw_fail  <= 1'b0;
            r_open_q   <= 1'b0;
            r_open_q2  <= 1'b0;
            r_close_q  <= 1'b0;
            r_close_q2 <= 1'b0;
        end else begin
            r_pw_ok    <= pw_ok;
            r_pw_fail  <= pw_fail;
            r_open_q   <= open_button;
            r_open_q2  <= r_open_q;
            r_close_q  <= close_sensor;
            r_close_q2 <= r_close_q;
        end
    end

    // Held levels produce a single pulse.
    assign w_open_re  = r_open_q  & ~r_open_q2;
    assign w_close_re = r_close_q & ~r_close_q2;

    lock_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .zero     (w_tmr_zero)
    );

    // State, failure count and Moore outputs, all updated from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_LOCKED;
            r_fail_cnt <= 2'd0;
            r_unlock   <= 1'b0;
            r_alert    <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_fail_cnt <= w_fail_nx;
            r_unlock   <= (w_state_nx == S_UNLOCKED) || (w_state_nx == S_AJAR);
            r_alert    <= (w_state_nx == S_AJAR) || (w_state_nx == S_LOCKOUT);
            r_lockout  <= (w_state_nx == S_LOCKOUT);
        end
    end

    // Next-state, failure-count and timer control; a simultaneous pw_ok/pw_fail
    // counts as a failure, and the interior button always gets the user out.
    always_comb begin
        w_state_nx = r_state;
        w_fail_nx  = r_fail_cnt;
        w_tmr_load = 1'b0;
        w_tmr_val  = AJAR_VAL;
        w_tmr_en   = 1'b0;
        case (r_state)
            S_LOCKED: begin
                if (w_open_re) begin
                    w_state_nx = S_UNLOCKED;
                    w_fail_nx  = 2'd0;
                    w_tmr_load = 1'b1;
                end else if (r_pw_fail) begin
                    w_fail_nx = sat_inc(r_fail_cnt, MAX_FAIL_V);
                    if (w_fail_nx == MAX_FAIL_V) begin
                        w_state_nx = S_LOCKOUT;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = LOCK_VAL;
                    end
                end else if (r_pw_ok) begin
                    w_state_nx = S_UNLOCKED;
                    w_fail_nx  = 2'd0;
                    w_tmr_load = 1'b1;
                end
            end
            S_UNLOCKED: begin
                if (w_close_re) begin
                    w_state_nx = S_LOCKED;
                end else if (r_pw_ok || w_open_re) begin
                    w_tmr_load = 1'b1;
                end else if (w_tmr_zero) begin
                    w_state_nx = S_AJAR;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            S_AJAR: begin
                if (w_close_re) begin
                    w_state_nx = S_LOCKED;
                end
            end
            S_LOCKOUT: begin
                if (w_open_re) begin
                    w_state_nx = S_UNLOCKED;
                    w_fail_nx  = 2'd0;
                    w_tmr_load = 1'b1;
                end else if (w_tmr_zero) begin
                    w_state_nx = S_LOCKED;
                    w_fail_nx  = 2'd0;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
        endcase
    end

    assign unlock   = r_unlock;
    assign alert    = r_alert;
    assign lockout  = r_lockout;
    assign fail_cnt = r_fail_cnt;
    assign state    = r_state;

endmodule

// File: tb/tb_door_lock_sequencer.sv
// Directed bench for door_lock_sequencer with hand-computed expectations.
module tb_door_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pw_ok = 1'b0;
    logic       pw_fail = 1'b0;
    logic       open_button = 1'b0;
    logic       close_sensor = 1'b0;
    logic       unlock;
    logic       alert;
    logic       lockout;
    logic [1:0] fail_cnt;
    logic [1:0] state;

    int n_total = 0;
    int n_bad   = 0;

    door_lock_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .pw_ok        (pw_ok),
        .pw_fail      (pw_fail),
        .open_button  (open_button),
        .close_sensor (close_sensor),
        .unlock       (unlock),
        .alert        (alert),
        .lockout      (lockout),
        .fail_cnt     (fail_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Input driven for one cycle, then one more edge for the registered result.
    task automatic pulse_ok();
        pw_ok = 1'b1; tick(); pw_ok = 1'b0; tick();
    endtask

    task automatic pulse_fail();
        pw_fail = 1'b1; tick(); pw_fail = 1'b0; tick();
    endtask

    task automatic pulse_close();
        close_sensor = 1'b1; tick(); close_sensor = 1'b0; tick();
    endtask

    task automatic outs(input string tag, input logic [1:0] st, input logic ul,
                        input logic al, input logic lo, input logic [1:0] fc);
        check({tag, ".state"},   32'(state),    32'(st));
        check({tag, ".unlock"},  32'(unlock),   32'(ul));
        check({tag, ".alert"},   32'(alert),    32'(al));
        check({tag, ".lockout"}, 32'(lockout),  32'(lo));
        check({tag, ".fail"},    32'(fail_cnt), 32'(fc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset
        #1 reset = 1'b1;
        #2;
        outs("reset", 2'd0, 0, 0, 0, 2'd0);
        tick(2);
        reset = 1'b0;
        tick();
        outs("idle", 2'd0, 0, 0, 0, 2'd0);

        // Correct code, then door closed
        pulse_ok();
        outs("ok", 2'd1, 1, 0, 0, 2'd0);
        close_sensor = 1'b1; tick(2);
        outs("close", 2'd0, 0, 0, 0, 2'd0);
        close_sensor = 1'b0; tick();

        // Lockout after three failures; pw_ok ignored during it
        pulse_fail();
        outs("fail1", 2'd0, 0, 0, 0, 2'd1);
        pulse_fail();
        outs("fail2", 2'd0, 0, 0, 0, 2'd2);
        pulse_fail();
        outs("fail3", 2'd3, 0, 1, 1, 2'd3);
        pulse_ok();
        outs("lo_ok", 2'd3, 0, 1, 1, 2'd3);
        tick(57);
        outs("lo_last", 2'd3, 0, 1, 1, 2'd3);
        tick();
        outs("lo_end", 2'd0, 0, 0, 0, 2'd0);

        // Door ajar after 20 cycles unlocked
        pulse_ok();
        tick(19);
        outs("aj_pre", 2'd1, 1, 0, 0, 2'd0);
        tick();
        outs("ajar", 2'd2, 1, 1, 0, 2'd0);
        pulse_ok();
        outs("aj_ok", 2'd2, 1, 1, 0, 2'd0);
        pulse_close();
        outs("aj_close", 2'd0, 0, 0, 0, 2'd0);

        // Held open button: one unlock, no timer reload
        open_button = 1'b1; tick(2);
        outs("open", 2'd1, 1, 0, 0, 2'd0);
        tick(6);
        open_button = 1'b0;
        tick(13);
        outs("open_pre", 2'd1, 1, 0, 0, 2'd0);
        tick();
        outs("open_ajar", 2'd2, 1, 1, 0, 2'd0);
        pulse_close();
        outs("open_close", 2'd0, 0, 0, 0, 2'd0);

        // Interior egress from lockout
        pulse_fail(); pulse_fail(); pulse_fail();
        outs("lo2", 2'd3, 0, 1, 1, 2'd3);
        open_button = 1'b1; tick(2);
        outs("lo_open", 2'd1, 1, 0, 0, 2'd0);
        open_button = 1'b0;
        pulse_close();
        outs("lo_open_close", 2'd0, 0, 0, 0, 2'd0);

        // Simultaneous ok+fail counts as failure; partial failures cleared by ok
        pw_ok = 1'b1; pw_fail = 1'b1; tick();
        pw_ok = 1'b0; pw_fail = 1'b0; tick();
        outs("both", 2'd0, 0, 0, 0, 2'd1);
        pulse_fail();
        outs("both_fail2", 2'd0, 0, 0, 0, 2'd2);
        pulse_ok();
        outs("part_ok", 2'd1, 1, 0, 0, 2'd0);
        pulse_close();
        outs("part_close", 2'd0, 0, 0, 0, 2'd0);

        // Asynchronous reset mid-lockout (timer at 30)
        pulse_fail(); pulse_fail(); pulse_fail();
        tick(29);
        outs("lo3", 2'd3, 0, 1, 1, 2'd3);
        reset = 1'b1;
        #2;
        outs("async_rst", 2'd0, 0, 0, 0, 2'd0);
        tick();
        reset = 1'b0;
        tick();
        outs("post_rst", 2'd0, 0, 0, 0, 2'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
